kbd_event_scheduler: RTL and testbench

//  Queues release scancodes from the PS/2 receiver (8-bit code + 1-cycle enable strobe) in a small FIFO.

---
 rtl/kbd_sched_pkg.sv | 13 +
 rtl/kbd_evt_fifo.sv | 55 +++++
 rtl/kbd_event_scheduler.sv | 124 ++++++++++++
 tb/tb_kbd_event_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_sched_pkg.sv
// Shared constants for the keyboard event scheduler: scancode width, FSM state
// encoding and consumer indices.
package kbd_sched_pkg;

    localparam int unsigned SCAN_W = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SERVE = 1'b1;

    localparam logic CONS0 = 1'b0;
    localparam logic CONS1 = 1'b1;

endpackage

// File: rtl/kbd_evt_fifo.sv
// Single-clock FIFO for release scancodes. A push into a full FIFO is accepted
// only when a pop happens at the same edge.
module kbd_evt_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/kbd_event_scheduler.sv
// Queues PS/2 release scancodes and hands each one to exactly one of two
// consumers, round-robin. Define KBD_SCHED_TIMEOUT_EN to expire stalled grants.
module kbd_event_scheduler
    import kbd_sched_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 50000,
    parameter int unsigned TW      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SCAN_W-1:0]        kbd_scancode,
    input  logic                     kbd_enable,
    input  logic                     c0_req,
    input  logic                     c1_req,
    input  logic                     c0_ack,
    input  logic                     c1_ack,
    output logic                     c0_valid,
    output logic                     c1_valid,
    output logic [SCAN_W-1:0]        evt_code,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     timeout_flag,
    input  logic                     flags_clr
);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT >= (64'd1 << TW)) begin : g_bad_cfg
        $error("kbd_event_scheduler: invalid DEPTH/TIMEOUT/TW");
    end

    logic [0:0]        state;
    logic              grant;
    logic              rr_last;
    logic [SCAN_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              granted_ack;
    logic              pop;
    logic              expire;

    assign granted_ack = (grant == CONS1) ? c1_ack : c0_ack;
    assign pop         = (state == ST_SERVE) & granted_ack;
    assign c0_valid    = (state == ST_SERVE) & (grant == CONS0);
    assign c1_valid    = (state == ST_SERVE) & (grant == CONS1);
    assign evt_code    = (state == ST_SERVE) ? head : '0;

    kbd_evt_fifo #(
        .DEPTH (DEPTH),
        .W     (SCAN_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (kbd_enable),
        .push_data (kbd_scancode),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef KBD_SCHED_TIMEOUT_EN
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmr;

    // An ack in the last allowed cycle wins over expiry.
    assign expire = (state == ST_SERVE) & ~granted_ack & (tmr == TMR_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmr <= '0;
        else if (state == ST_SERVE)
            tmr <= tmr + 1'b1;
        else
            tmr <= '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            timeout_flag <= 1'b0;
        else if (expire)
            timeout_flag <= 1'b1;
        else if (flags_clr)
            timeout_flag <= 1'b0;
    end
`else
    assign expire       = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            grant   <= CONS0;
            rr_last <= CONS1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty && (c0_req || c1_req)) begin
                        state <= ST_SERVE;
                        grant <= (c0_req && c1_req) ? ~rr_last : c1_req;
                    end
                end
                ST_SERVE: begin
                    // Expiry also records the holder so the other side gets the retry.
                    if (granted_ack || expire) begin
                        state   <= ST_IDLE;
                        rr_last <= grant;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overflow <= 1'b0;
        else if (kbd_enable && fifo_full && !pop)
            overflow <= 1'b1;
        else if (flags_clr)
            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_kbd_event_scheduler.sv
// Scoreboard bench for kbd_event_scheduler: directed scenarios plus random
// traffic, checked by a negedge monitor against a queue-based event model.
module tb_kbd_event_scheduler;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] kbd_scancode = '0;
    logic       kbd_enable = 1'b0;
    logic       c0_req = 1'b0, c1_req = 1'b0, c0_ack = 1'b0, c1_ack = 1'b0;
    logic       flags_clr = 1'b0;
    logic       c0_valid, c1_valid, overflow, timeout_flag;
    logic [7:0] evt_code;
    logic [3:0] fifo_count;

    always #5 clk = ~clk;

    kbd_event_scheduler #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .TW      (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .kbd_scancode (kbd_scancode),
        .kbd_enable   (kbd_enable),
        .c0_req       (c0_req),
        .c1_req       (c1_req),
        .c0_ack       (c0_ack),
        .c1_ack       (c1_ack),
        .c0_valid     (c0_valid),
        .c1_valid     (c1_valid),
        .evt_code     (evt_code),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .timeout_flag (timeout_flag),
        .flags_clr    (flags_clr)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: pending events, sticky flags, last-served consumer.
    logic [7:0] model_q[$];
    logic [8:0] deliv_q[$];
    logic       m_ovf = 1'b0, m_tflag = 1'b0, m_rr = 1'b1, vcons = 1'b0;
    int         vcnt = 0;
    logic [1:0] grant_pat = 2'b00;

    always @(negedge clk) begin : monitor
        logic cur, hs, ovf_set, tf_set;
        if (reset) begin
            chk("rst_c0_valid", c0_valid, 0);
            chk("rst_c1_valid", c1_valid, 0);
            chk("rst_count", fifo_count, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_timeout", timeout_flag, 0);
            chk("rst_evt", evt_code, 0);
            model_q.delete();
            m_ovf = 1'b0; m_tflag = 1'b0; m_rr = 1'b1; vcnt = 0;
        end else begin
            ovf_set = 1'b0; tf_set = 1'b0; hs = 1'b0;
            cur = c1_valid;
            chk("fifo_count", fifo_count, model_q.size());
            chk("overflow", overflow, m_ovf);
            chk("timeout_flag", timeout_flag, m_tflag);
            chk("one_valid", c0_valid & c1_valid, 0);
            if (c0_valid || c1_valid) begin
                vcnt = (vcnt > 0 && cur == vcons) ? vcnt + 1 : 1;
                vcons = cur;
                if (vcnt == 1)
                    chk("grant_target", cur, (grant_pat == 2'b11) ? !m_rr : grant_pat[1]);
                if (model_q.size() == 0)
                    chk("valid_with_empty_model", 1, 0);
                else
                    chk("evt_head", evt_code, model_q[0]);
                hs = cur ? c1_ack : c0_ack;
                if (hs && model_q.size() > 0) begin
                    deliv_q.push_back({cur, model_q[0]});
                    void'(model_q.pop_front());
                    m_rr = cur;
                end
`ifdef KBD_SCHED_TIMEOUT_EN
                else if (!hs && vcnt == TIMEOUT) begin
                    m_rr = cur;
                    tf_set = 1'b1;
                end
                if (vcnt > TIMEOUT)
                    chk("grant_expiry", vcnt, TIMEOUT);
`endif
            end else begin
                vcnt = 0;
                chk("evt_idle_zero", evt_code, 0);
            end
            if (kbd_enable) begin
                if (model_q.size() < DEPTH)
                    model_q.push_back(kbd_scancode);
                else
                    ovf_set = 1'b1;
            end
            m_ovf   = ovf_set ? 1'b1 : (flags_clr ? 1'b0 : m_ovf);
            m_tflag = tf_set  ? 1'b1 : (flags_clr ? 1'b0 : m_tflag);
        end
    end

    // Consumer emulation: ack the granted side after 0..2 cycles, random noise on the other.
    logic rand_ack = 1'b0, in_grant = 1'b0;
    int   hold = 0, tgt = 0;

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ack) begin
            if (c0_valid || c1_valid) begin
                if (!in_grant) begin
                    in_grant = 1'b1; hold = 0; tgt = $urandom_range(0, 2);
                end else begin
                    hold++;
                end
                c0_ack = c0_valid ? (hold >= tgt) : 1'($urandom);
                c1_ack = c1_valid ? (hold >= tgt) : 1'($urandom);
            end else begin
                in_grant = 1'b0;
                c0_ack = 1'($urandom);
                c1_ack = 1'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1; kbd_enable = 1'b0; flags_clr = 1'b0; rand_ack = 1'b0;
        c0_req = 1'b0; c1_req = 1'b0; c0_ack = 1'b0; c1_ack = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic set_req(input logic [1:0] p);
        c0_req = p[0];
        c1_req = p[1];
        grant_pat = p;
    endtask

    task automatic push(input logic [7:0] code);
        kbd_scancode = code;
        kbd_enable = 1'b1;
        step();
        kbd_enable = 1'b0;
    endtask

    task automatic drain_all(input string name);
        int i;
        rand_ack = 1'b1;
        for (i = 0; i < 200 && (fifo_count != 0 || c0_valid || c1_valid); i++) step();
        if (i >= 200) chk(name, 0, 1);
        rand_ack = 1'b0; c0_ack = 1'b0; c1_ack = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n, idle;
        logic [1:0] pat;

        // Latency: strobe at edge N, offered after edge N+1, popped on ack.
        do_reset();
        set_req(2'b01);
        push(8'h1C);
        chk("t2_count_after_push", fifo_count, 1);
        chk("t2_valid_early", c0_valid, 0);
        step();
        chk("t2_c0_valid", c0_valid, 1);
        chk("t2_evt", evt_code, 8'h1C);
        c0_ack = 1'b1;
        step();
        c0_ack = 1'b0;
        chk("t2_count_after_ack", fifo_count, 0);
        chk("t2_valid_after_ack", c0_valid, 0);

        // Round-robin with both consumers acking immediately.
        do_reset();
        deliv_q.delete();
        set_req(2'b11);
        c0_ack = 1'b1; c1_ack = 1'b1;
        push(8'h1C); push(8'h32); push(8'h21);
        repeat (10) step();
        c0_ack = 1'b0; c1_ack = 1'b0;
        chk("t3_deliveries", deliv_q.size(), 3);
        if (deliv_q.size() == 3) begin
            chk("t3_first", deliv_q[0], {1'b0, 8'h1C});
            chk("t3_second", deliv_q[1], {1'b1, 8'h32});
            chk("t3_third", deliv_q[2], {1'b0, 8'h21});
        end

        // Overflow: nine pushes, no consumers.
        do_reset();
        for (int i = 0; i < 9; i++) push(8'(8'h10 + i));
        chk("t4_count_full", fifo_count, 8);
        chk("t4_overflow", overflow, 1);
        deliv_q.delete();
        set_req(2'b01);
        drain_all("t4_drain_timeout");
        chk("t4_pops", deliv_q.size(), 8);
        for (int i = 0; i < 8 && i < deliv_q.size(); i++)
            chk("t4_pop_order", deliv_q[i], {1'b0, 8'(8'h10 + i)});
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        chk("t4_overflow_cleared", overflow, 0);

        // Full FIFO, push and pop at the same edge.
        do_reset();
        for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
        chk("t6_count_full", fifo_count, 8);
        chk("t6_no_overflow", overflow, 0);
        set_req(2'b01);
        for (n = 0; n < 10 && !c0_valid; n++) step();
        chk("t6_c0_valid", c0_valid, 1);
        c0_ack = 1'b1; kbd_scancode = 8'h48; kbd_enable = 1'b1;
        step();
        c0_ack = 1'b0; kbd_enable = 1'b0;
        chk("t6_count_stays", fifo_count, 8);
        chk("t6_overflow_stays", overflow, 0);
        drain_all("t6_drain_timeout");

`ifdef KBD_SCHED_TIMEOUT_EN
        // Stalled grant to c0 expires and the same code moves to c1.
        do_reset();
        set_req(2'b11);
        push(8'h5A);
        for (n = 0; n < 5 && !c0_valid; n++) step();
        n = 0;
        while (c0_valid && n < 10) begin
            n++;
            step();
        end
        chk("t5_c0_valid_cycles", n, TIMEOUT);
        chk("t5_timeout_flag", timeout_flag, 1);
        for (n = 0; n < 5 && !c1_valid; n++) step();
        chk("t5_c1_valid", c1_valid, 1);
        chk("t5_same_code", evt_code, 8'h5A);
        c1_ack = 1'b1;
        step();
        c1_ack = 1'b0;
        chk("t5_count_after_ack", fifo_count, 0);
`endif

        // Random traffic in phases with a fixed request pattern per phase.
        do_reset();
        rand_ack = 1'b1;
        for (int ph = 0; ph < 12; ph++) begin
            c0_req = 1'b0; c1_req = 1'b0;
            idle = 0;
            for (n = 0; n < 50 && idle < 2; n++) begin
                step();
                idle = (c0_valid || c1_valid) ? 0 : idle + 1;
            end
            if (idle < 2) chk("rand_drain_timeout", 0, 1);
            pat = 2'($urandom_range(0, 3));
            set_req(pat);
            repeat (40) begin
                kbd_enable   = ($urandom_range(0, 2) == 0);
                kbd_scancode = 8'($urandom);
                flags_clr    = ($urandom_range(0, 15) == 0);
                step();
            end
            kbd_enable = 1'b0; flags_clr = 1'b0;
        end

        // Asynchronous reset while an event is being offered.
        rand_ack = 1'b0; c0_ack = 1'b0; c1_ack = 1'b0;
        set_req(2'b11);
        push(8'h66); push(8'h67); push(8'h68);
        for (n = 0; n < 5 && !(c0_valid || c1_valid); n++) step();
        chk("t1_serving_before_reset", c0_valid | c1_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("t1_c0_valid", c0_valid, 0);
        chk("t1_c1_valid", c1_valid, 0);
        chk("t1_count", fifo_count, 0);
        chk("t1_overflow", overflow, 0);
        chk("t1_timeout", timeout_flag, 0);
        step();
        step();
        reset = 1'b0;
        c0_req = 1'b0; c1_req = 1'b0;
        step();
        chk("t1_count_after_release", fifo_count, 0);

`ifndef KBD_SCHED_TIMEOUT_EN
        chk("no_timeout_flag", timeout_flag, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
